// File: rtl/riscv_alu_mc.sv
// riscv_alu_mc: multi-cycle integer ALU for the RISC-V unicycle datapath.
// Single-cycle ops (AND/OR/ADD/SUB/SLT/SLTU/shifts/NOR) are captured the
// cycle they are accepted. MUL (shift-add), DIVU and REMU (restoring
// division) iterate one bit per cycle for XLEN cycles. Results are held
// under a valid/ready handshake until the consumer takes them.
module riscv_alu_mc #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctl,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   input  logic            zero_clr,
   output logic            busy
);

   // Operation encoding shared with the single-cycle ALU, plus the three
   // iterative ops in the formerly spare codes.
   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_SLTU = 4'd11;
   localparam logic [3:0] OP_NOR  = 4'd12;
   localparam logic [3:0] OP_MUL  = 4'd13;
   localparam logic [3:0] OP_DIVU = 4'd14;
   localparam logic [3:0] OP_REMU = 4'd15;

   // The iteration counter must be able to hold XLEN itself.
   localparam logic [SHW:0] CNT_INIT = (SHW+1)'(XLEN);
   localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   // Operand / working registers. For MUL, a_r is the left-shifting
   // multiplicand, b_r the right-shifting multiplier and acc_r the running
   // product. For DIVU/REMU, a_r shifts the dividend out of its top while the
   // quotient bits shift in at the bottom, and acc_r is the partial remainder.
   logic [3:0]      op_r;
   logic [XLEN-1:0] a_r;
   logic [XLEN-1:0] b_r;
   logic [XLEN-1:0] acc_r;
   logic [SHW:0]    cnt_r;

   logic            accept;
   logic            iter_op;
   logic            last_step;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] acc_nx;
   logic [XLEN-1:0] a_nx;
   logic [XLEN-1:0] b_nx;
   logic [XLEN-1:0] iter_res;
   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   diff;

   assign accept    = in_valid && (state == IDLE);
   assign iter_op   = (alu_ctl == OP_MUL) || (alu_ctl == OP_DIVU) || (alu_ctl == OP_REMU);
   assign last_step = (state == ITER) && (cnt_r == CNT_ONE);

   // Outputs are pure state decodes, so no input reaches an output
   // combinationally.
   assign in_ready  = (state == IDLE);
   assign busy      = (state == ITER);
   assign out_valid = (state == DONE);

   // Single-cycle result, computed straight from the accept-cycle operands.
   always_comb begin
      // NOTE: every combinational output gets a default before the case so
      // that no path through the block leaves it unassigned (no latch).
      alu_res = '0;
      case (alu_ctl)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_SLT:  alu_res[0] = ($signed(a) < $signed(b));
         OP_SLTU: alu_res[0] = (a < b);
         OP_SLL:  alu_res = a << b[SHW-1:0];
         OP_SRL:  alu_res = a >> b[SHW-1:0];
         OP_SRA:  alu_res = $signed(a) >>> b[SHW-1:0];
         OP_NOR:  alu_res = ~(a | b);
         default: alu_res = '0;
      endcase
   end

   // One shift-add or restoring-division step per ITER cycle.
   always_comb begin
      acc_nx = acc_r;
      a_nx   = a_r;
      b_nx   = b_r;
      rem_sh = {acc_r, a_r[XLEN-1]};
      diff   = rem_sh - {1'b0, b_r};
      if (op_r == OP_MUL) begin
         if (b_r[0]) begin
            acc_nx = acc_r + a_r;
         end
         a_nx = a_r << 1;
         b_nx = b_r >> 1;
      end else begin
         // A clear top bit of diff means the shifted remainder covered the
         // divisor: keep the difference and shift in a 1. A zero divisor
         // always "covers", giving all-ones quotient and remainder = a.
         if (!diff[XLEN]) begin
            acc_nx = diff[XLEN-1:0];
            a_nx   = {a_r[XLEN-2:0], 1'b1};
         end else begin
            acc_nx = rem_sh[XLEN-1:0];
            a_nx   = {a_r[XLEN-2:0], 1'b0};
         end
      end
   end

   // Pick which working register holds the finished iterative answer.
   always_comb begin
      iter_res = acc_nx;
      if (op_r == OP_DIVU) begin
         iter_res = a_nx;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: IDLE accepts, ITER counts down, DONE waits for the
   // consumer. There is deliberately no same-cycle accept from DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = iter_op ? ITER : DONE;
            end
         end
         ITER: begin
            if (cnt_r == CNT_ONE) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand latch, iteration datapath and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r   <= '0;
         a_r    <= '0;
         b_r    <= '0;
         acc_r  <= '0;
         cnt_r  <= '0;
         result <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of block order.
         if (accept) begin
            op_r  <= alu_ctl;
            a_r   <= a;
            b_r   <= b;
            acc_r <= '0;
            if (iter_op) begin
               cnt_r <= CNT_INIT;
            end else begin
               result <= alu_res;
            end
         end else if (state == ITER) begin
            acc_r <= acc_nx;
            a_r   <= a_nx;
            b_r   <= b_nx;
            cnt_r <= cnt_r - CNT_ONE;
            if (last_step) begin
               result <= iter_res;
            end
         end
      end
   end

   // Branch-compare flag: only SUB can set it; a clear request always wins,
   // even over a capture in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b0;
      end else if (zero_clr) begin
         zero <= 1'b0;
      end else if (accept && !iter_op) begin
         zero <= (alu_ctl == OP_SUB) && (alu_res == '0);
      end else if (last_step) begin
         zero <= 1'b0;
      end
   end

endmodule

// File: tb/tb_riscv_alu_mc.sv
// Bench for riscv_alu_mc: directed cases plus randomized ops against a
// plain-arithmetic reference model. Expected responses go into a queue when
// an op is issued; a monitor pops and compares on every output handshake.
// A second, XLEN=8 instance covers the narrow build.
module tb_riscv_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, in_ready, out_valid, out_ready, zero, zero_clr, busy;
   logic [3:0]  alu_ctl;
   logic [31:0] a, b, result;

   logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, zero_8, zero_clr_8, busy_8;
   logic [3:0]  alu_ctl_8;
   logic [7:0]  a_8, b_8, result_8;

   logic        rand_ready;
   int          n_cmp = 0;
   int          n_err = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] res;
      logic        z;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   riscv_alu_mc #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctl(alu_ctl), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero),
      .zero_clr(zero_clr), .busy(busy)
   );

   riscv_alu_mc #(.XLEN(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
      .alu_ctl(alu_ctl_8), .a(a_8), .b(b_8), .out_valid(out_valid_8),
      .out_ready(out_ready_8), .result(result_8), .zero(zero_8),
      .zero_clr(zero_clr_8), .busy(busy_8)
   );

   // Reference model: the operation table with ordinary arithmetic.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
      logic [63:0] p;
      case (op)
         4'd0:  return x & y;
         4'd1:  return x | y;
         4'd2:  return x + y;
         4'd6:  return x - y;
         4'd7:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd11: return (x < y) ? 32'd1 : 32'd0;
         4'd8:  return x << y[4:0];
         4'd9:  return x >> y[4:0];
         4'd10: return $signed(x) >>> y[4:0];
         4'd12: return ~(x | y);
         4'd13: begin
            p = {32'd0, x} * {32'd0, y};
            return p[31:0];
         end
         4'd14: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         4'd15: return (y == 0) ? x : x % y;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every completed handshake is compared with the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("op%0d_result", e.op), {32'd0, result}, {32'd0, e.res});
            check($sformatf("op%0d_zero", e.op), {63'd0, zero}, {63'd0, e.z});
         end
      end
   end

   // Random back-pressure, changed well away from the sampling points.
   always begin
      @(posedge clk);
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // All stimulus tasks are entered and left 1 time unit after a rising edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input bit clr);
      int n = 0;
      exp_t e;
      while (!in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL issue_timeout: in_ready got 0, expected 1");
         return;
      end
      in_valid = 1'b1;
      alu_ctl  = op;
      a        = av;
      b        = bv;
      zero_clr = clr;
      e.op  = op;
      e.res = ref_alu(op, av, bv);
      e.z   = (op == 4'd6) && (av == bv) && !clr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      zero_clr = 1'b0;
      a        = $urandom;
      b        = $urandom;
      alu_ctl  = 4'($urandom);
   endtask

   task automatic wait_out(input string name);
      int n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!out_valid) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: out_valid got 0, expected 1", name);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic op8(input string name, input logic [3:0] op, input logic [7:0] av,
                      input logic [7:0] bv, input logic [7:0] req, input int req_busy);
      int n = 0;
      while (!in_ready_8 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      in_valid_8 = 1'b1;
      alu_ctl_8  = op;
      a_8        = av;
      b_8        = bv;
      @(posedge clk);
      #1;
      in_valid_8 = 1'b0;
      n = 0;
      while (busy_8 && n < 50) begin
         n++;
         @(posedge clk);
         #1;
      end
      check({name, "_busy_cycles"}, 64'(n), 64'(req_busy));
      check({name, "_out_valid"}, {63'd0, out_valid_8}, 64'd1);
      check({name, "_result"}, {56'd0, result_8}, {56'd0, req});
      check({name, "_zero"}, {63'd0, zero_8}, 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   n;
      logic [3:0]  op;
      logic [31:0] av, bv;
      exp_t e;

      rst_n = 1'b0;  rand_ready = 1'b0;
      in_valid = 1'b0;  out_ready = 1'b1;  zero_clr = 1'b0;
      alu_ctl = '0;  a = '0;  b = '0;
      in_valid_8 = 1'b0;  out_ready_8 = 1'b1;  zero_clr_8 = 1'b0;
      alu_ctl_8 = '0;  a_8 = '0;  b_8 = '0;

      // Reset values.
      #12;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_result", {32'd0, result}, 64'd0);
      check("rst_zero", {63'd0, zero}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADD: one-cycle latency, in_ready back one cycle after the handshake.
      issue(4'd2, 32'd7, 32'd5, 1'b0);
      check("add_out_valid", {63'd0, out_valid}, 64'd1);
      check("add_result", {32'd0, result}, 64'd12);
      @(posedge clk);
      #1;
      check("add_in_ready_back", {63'd0, in_ready}, 64'd1);

      // SUB equal operands, then clear zero while the result is held.
      out_ready = 1'b0;
      issue(4'd6, 32'd9, 32'd9, 1'b0);
      check("sub_zero_set", {63'd0, zero}, 64'd1);
      check("sub_result", {32'd0, result}, 64'd0);
      zero_clr = 1'b1;
      @(posedge clk);
      #1;
      zero_clr = 1'b0;
      check("zero_clr_zero", {63'd0, zero}, 64'd0);
      check("zero_clr_result", {32'd0, result}, 64'd0);
      check("zero_clr_out_valid", {63'd0, out_valid}, 64'd1);
      e = exp_q.pop_back();
      e.z = 1'b0;
      exp_q.push_back(e);
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Clear coinciding with the capture wins.
      issue(4'd6, 32'd9, 32'd9, 1'b1);
      check("sub_clr_capture_zero", {63'd0, zero}, 64'd0);

      // Signed compare and shifts.
      issue(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
      check("slt_neg", {32'd0, result}, 64'd1);
      issue(4'd11, 32'hFFFF_FFFF, 32'd1, 1'b0);
      check("sltu_big", {32'd0, result}, 64'd0);
      issue(4'd10, 32'h8000_0000, 32'h24, 1'b0);
      check("sra_shift4", {32'd0, result}, 64'hF800_0000);
      issue(4'd12, 32'd0, 32'd0, 1'b0);
      check("nor_zero", {32'd0, result}, 64'hFFFF_FFFF);

      // MUL: busy for exactly XLEN cycles, wrapped product.
      issue(4'd13, 32'h0001_0000, 32'h0001_0001, 1'b0);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      check("mul_busy_cycles", 64'(n), 64'd32);
      check("mul_out_valid", {63'd0, out_valid}, 64'd1);
      check("mul_result", {32'd0, result}, 64'h0001_0000);
      @(posedge clk);
      #1;

      issue(4'd14, 32'd100, 32'd7, 1'b0);
      wait_out("divu");
      check("divu_100_7", {32'd0, result}, 64'd14);
      @(posedge clk);
      #1;
      issue(4'd15, 32'd100, 32'd7, 1'b0);
      wait_out("remu");
      check("remu_100_7", {32'd0, result}, 64'd2);
      @(posedge clk);
      #1;

      // Divide by zero with the result held for five cycles.
      out_ready = 1'b0;
      issue(4'd14, 32'd123, 32'd0, 1'b0);
      wait_out("divu_by0");
      for (int i = 0; i < 5; i++) begin
         check("hold_result", {32'd0, result}, 64'hFFFF_FFFF);
         check("hold_in_ready", {63'd0, in_ready}, 64'd0);
         check("hold_out_valid", {63'd0, out_valid}, 64'd1);
         if (i == 2) begin
            in_valid = 1'b1;
            alu_ctl  = 4'd2;
            a        = 32'd1;
            b        = 32'd1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      issue(4'd15, 32'd123, 32'd0, 1'b0);
      wait_out("remu_by0");
      check("remu_by0", {32'd0, result}, 64'd123);
      @(posedge clk);
      #1;

      // Randomized ops under random back-pressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         av = $urandom;
         bv = $urandom;
         if ($urandom_range(0, 3) == 0) bv = av;
         if (op >= 4'd14 && $urandom_range(0, 1) == 1) bv = $urandom_range(0, 20);
         issue(op, av, bv, 1'b0);
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();

      // Reset ten cycles into a DIVU aborts it.
      issue(4'd14, $urandom, 32'd7, 1'b0);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", {63'd0, out_valid}, 64'd0);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_result", {32'd0, result}, 64'd0);
      check("abort_in_ready", {63'd0, in_ready}, 64'd1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(4'd2, 32'd3, 32'd4, 1'b0);
      check("post_reset_add", {32'd0, result}, 64'd7);
      drain();

      // Narrow build.
      op8("mul8", 4'd13, 8'd15, 8'd17, 8'(15 * 17), 8);
      op8("divu8", 4'd14, 8'd200, 8'd7, 8'(200 / 7), 8);
      op8("remu8", 4'd15, 8'd200, 8'd7, 8'(200 % 7), 8);
      op8("divu8_by0", 4'd14, 8'd55, 8'd0, 8'hFF, 8);
      op8("add8_wrap", 4'd2, 8'd200, 8'd100, 8'(300 - 256), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
